// File: rtl/sbox_layer_pkg.sv
// sbox_layer_pkg: shared definitions for the pipelined masked S-box layer.
//   - SHARES, SR_W, DR_W: share count and default randomness widths
//   - fsm_state_t: guard-seeding state (FILL, RUN)
//   - byte-index helpers, static-randomness rotation amount
//   - sbox_fwd: unmasked AES S-box (GF(2^8) inverse + affine map), used by
//     the core model to recombine and re-split shares
package sbox_layer_pkg;

  localparam int SHARES = 3;
  localparam int SR_W   = 139;
  localparam int DR_W   = 16;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  function automatic int byte_row(input int idx);
    return idx % 4;
  endfunction

  function automatic int byte_col(input int idx);
    return idx / 4;
  endfunction

  function automatic int byte_idx(input int col, input int row);
    return 4 * col + row;
  endfunction

  // Left-rotation applied to static randomness for a given byte index.
  function automatic int rot_amt(input int idx, input int step, input int width);
    return (idx * step) % width;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Inverse as x^254 (square-and-multiply), then the AES affine map.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox_col.sv
// sbox_col: one state column (4 bytes) of masked S-box cores.
//   s1..s3 / o1..o3   32-bit column shares, row r at [8r+:8]
//   static_r          static randomness, rotated per global byte index
//   dynamic_r         4 row slots of DR_W bits, row r at [DR_W*r+:DR_W]
//   guard_in          guard seed entering at row 3
//   guard_top         guard leaving row 0 (feeds the recycle register)
// ROT_STEP = 0 disables the static-randomness rotation.
module sbox_col #(
  parameter int COL      = 0,
  parameter int SBOX_LAT = 4,
  parameter int SR_W     = sbox_layer_pkg::SR_W,
  parameter int DR_W     = sbox_layer_pkg::DR_W,
  parameter int ROT_STEP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s1,
  input  logic [31:0]       s2,
  input  logic [31:0]       s3,
  input  logic [SR_W-1:0]   static_r,
  input  logic [4*DR_W-1:0] dynamic_r,
  input  logic [7:0]        guard_in,
  output logic [7:0]        guard_top,
  output logic [31:0]       o1,
  output logic [31:0]       o2,
  output logic [31:0]       o3
);
  import sbox_layer_pkg::*;

  logic [SR_W-1:0] row_sr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam int IDX = byte_idx(COL, gi);
      localparam int ROT = rot_amt(IDX, ROT_STEP, SR_W);

      logic [7:0] guard_in_w;
      logic [7:0] guard_out_w;

      if (ROT == 0) begin : g_norot
        assign row_sr[gi] = static_r;
      end else begin : g_rot
        assign row_sr[gi] = {static_r[SR_W-1-ROT:0], static_r[SR_W-1:SR_W-ROT]};
      end

      // Guard flows from row 3 down to row 0 within the column.
      if (gi == 3) begin : g_head
        assign guard_in_w = guard_in;
      end else begin : g_link
        assign guard_in_w = g_row[gi+1].guard_out_w;
      end

      sbox_masked_core #(
        .SBOX_LAT (SBOX_LAT),
        .SR_W     (SR_W),
        .DR_W     (DR_W)
      ) u_core (
        .clk       (clk),
        .rst       (rst),
        .s1        (s1[8*gi+:8]),
        .s2        (s2[8*gi+:8]),
        .s3        (s3[8*gi+:8]),
        .static_r  (row_sr[gi]),
        .dynamic_r (dynamic_r[DR_W*byte_row(IDX)+:DR_W]),
        .guard_in  (guard_in_w),
        .guard_out (guard_out_w),
        .o1        (o1[8*gi+:8]),
        .o2        (o2[8*gi+:8]),
        .o3        (o3[8*gi+:8])
      );
    end
  endgenerate

  assign guard_top = g_row[0].guard_out_w;

endmodule

// File: rtl/sbox_masked_core.sv
// sbox_masked_core: 3-share masked S-box core, fixed latency SBOX_LAT.
//   clk, rst            clock, asynchronous active-high reset
//   s1, s2, s3          input byte shares
//   static_r, dynamic_r randomness for this byte
//   guard_in/guard_out  guard share chain (guard_out is combinational)
//   o1, o2, o3          output byte shares, SBOX_LAT cycles after input
// This is a functional model of the hardened core: it recombines the shares,
// substitutes, and re-splits with masks drawn from guard and randomness.
module sbox_masked_core #(
  parameter int SBOX_LAT = 4,
  parameter int SR_W     = sbox_layer_pkg::SR_W,
  parameter int DR_W     = sbox_layer_pkg::DR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      s1,
  input  logic [7:0]      s2,
  input  logic [7:0]      s3,
  input  logic [SR_W-1:0] static_r,
  input  logic [DR_W-1:0] dynamic_r,
  input  logic [7:0]      guard_in,
  output logic [7:0]      guard_out,
  output logic [7:0]      o1,
  output logic [7:0]      o2,
  output logic [7:0]      o3
);
  import sbox_layer_pkg::*;

  function automatic logic [7:0] fold_sr(input logic [SR_W-1:0] v);
    logic [7:0] f;
    f = '0;
    for (int j = 0; j < SR_W; j++) f[j % 8] = f[j % 8] ^ v[j];
    return f;
  endfunction

  function automatic logic [7:0] fold_dr(input logic [DR_W-1:0] v);
    logic [7:0] f;
    f = '0;
    for (int j = 0; j < DR_W; j++) f[j % 8] = f[j % 8] ^ v[j];
    return f;
  endfunction

  logic [7:0] sr_fold;
  logic [7:0] dr_fold;
  logic [7:0] mask_a;
  logic [7:0] mask_b;
  logic [7:0] plain;

  assign sr_fold   = fold_sr(static_r);
  assign dr_fold   = fold_dr(dynamic_r);
  assign plain     = sbox_fwd(s1 ^ s2 ^ s3);
  assign mask_a    = dr_fold ^ guard_in;
  assign mask_b    = sr_fold ^ {guard_in[4:0], guard_in[7:5]};
  assign guard_out = {guard_in[6:0], guard_in[7]} ^ dr_fold;

  logic [7:0] sh1_reg [SBOX_LAT];
  logic [7:0] sh2_reg [SBOX_LAT];
  logic [7:0] sh3_reg [SBOX_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SBOX_LAT; k++) begin
        sh1_reg[k] <= '0;
        sh2_reg[k] <= '0;
        sh3_reg[k] <= '0;
      end
    end else begin
      sh1_reg[0] <= plain ^ mask_a ^ mask_b;
      sh2_reg[0] <= mask_a;
      sh3_reg[0] <= mask_b;
      for (int k = 1; k < SBOX_LAT; k++) begin
        sh1_reg[k] <= sh1_reg[k-1];
        sh2_reg[k] <= sh2_reg[k-1];
        sh3_reg[k] <= sh3_reg[k-1];
      end
    end
  end

  assign o1 = sh1_reg[SBOX_LAT-1];
  assign o2 = sh2_reg[SBOX_LAT-1];
  assign o3 = sh3_reg[SBOX_LAT-1];

endmodule

// File: rtl/sbox_layer_pipe.sv
// sbox_layer_pipe: pipelined 3-share masked S-box layer over 4*NUM_COL bytes.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (ready only once guards are seeded)
//   in_s1..in_s3          input shares, byte i at [8i+:8]
//   static_r, dynamic_r   randomness, sampled with the data
//   guards_in/_valid      external guard seeds, one byte per column
//   reseed                restart guard seeding
//   out_valid, out_s1..3  result shares, SBOX_LAT cycles after acceptance
//   seeded                guard recycle register is full (RUN)
// Build option: define STATIC_ROTATE_EN to rotate static_r per byte by
// i*ROT_STEP; otherwise every byte sees static_r unrotated.
module sbox_layer_pipe #(
  parameter int NUM_COL     = 4,
  parameter int SBOX_LAT    = 4,
  parameter int GUARD_DEPTH = 10,
  parameter int SR_W        = sbox_layer_pkg::SR_W,
  parameter int DR_W        = sbox_layer_pkg::DR_W,
  parameter int ROT_STEP    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NUM_COL-1:0] in_s1,
  input  logic [32*NUM_COL-1:0] in_s2,
  input  logic [32*NUM_COL-1:0] in_s3,
  input  logic [SR_W-1:0]      static_r,
  input  logic [4*DR_W-1:0]    dynamic_r,
  input  logic [8*NUM_COL-1:0] guards_in,
  input  logic                 guards_valid,
  input  logic                 reseed,
  output logic                 out_valid,
  output logic [32*NUM_COL-1:0] out_s1,
  output logic [32*NUM_COL-1:0] out_s2,
  output logic [32*NUM_COL-1:0] out_s3,
  output logic                 seeded
);
  import sbox_layer_pkg::*;

  localparam int CNT_W = (GUARD_DEPTH > 1) ? $clog2(GUARD_DEPTH) : 1;
`ifdef STATIC_ROTATE_EN
  localparam int ROT_EFF = ROT_STEP;
`else
  localparam int ROT_EFF = 0 * ROT_STEP;
`endif

  fsm_state_t           state_reg;
  logic [CNT_W-1:0]     fill_cnt_reg;
  logic                 seeded_reg;
  logic [SBOX_LAT-1:0]  valid_sr_reg;
  logic [8*NUM_COL-1:0] guard_sr_reg [GUARD_DEPTH];
  logic [8*NUM_COL-1:0] guard_mux;
  logic [8*NUM_COL-1:0] guard_cat;
  logic                 accept;

  assign in_ready  = seeded_reg;
  assign seeded    = seeded_reg;
  assign accept    = in_valid & seeded_reg;
  assign out_valid = valid_sr_reg[SBOX_LAT-1];
  assign guard_mux = (state_reg == RUN) ? guard_sr_reg[0] : guards_in;

  // Guard seeding FSM; seeded_reg mirrors (state == RUN) as a registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
      seeded_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (reseed) begin
            fill_cnt_reg <= '0;
          end else if (guards_valid) begin
            if (fill_cnt_reg == CNT_W'(GUARD_DEPTH - 1)) begin
              state_reg    <= RUN;
              seeded_reg   <= 1'b1;
              fill_cnt_reg <= '0;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end
        RUN: begin
          if (reseed) begin
            state_reg    <= FILL;
            seeded_reg   <= 1'b0;
            fill_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg    <= FILL;
          seeded_reg   <= 1'b0;
          fill_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Valid tracking and guard recycling both advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr_reg <= '0;
      for (int k = 0; k < GUARD_DEPTH; k++) guard_sr_reg[k] <= '0;
    end else begin
      valid_sr_reg[0] <= accept;
      for (int k = 1; k < SBOX_LAT; k++) valid_sr_reg[k] <= valid_sr_reg[k-1];
      for (int k = 0; k < GUARD_DEPTH - 1; k++) guard_sr_reg[k] <= guard_sr_reg[k+1];
      guard_sr_reg[GUARD_DEPTH-1] <= guard_cat;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      logic [7:0] col_guard_top;

      sbox_col #(
        .COL      (gi),
        .SBOX_LAT (SBOX_LAT),
        .SR_W     (SR_W),
        .DR_W     (DR_W),
        .ROT_STEP (ROT_EFF)
      ) u_col (
        .clk       (clk),
        .rst       (rst),
        .s1        (in_s1[32*gi+:32]),
        .s2        (in_s2[32*gi+:32]),
        .s3        (in_s3[32*gi+:32]),
        .static_r  (static_r),
        .dynamic_r (dynamic_r),
        .guard_in  (guard_mux[8*gi+:8]),
        .guard_top (col_guard_top),
        .o1        (out_s1[32*gi+:32]),
        .o2        (out_s2[32*gi+:32]),
        .o3        (out_s3[32*gi+:32])
      );

      assign guard_cat[8*gi+:8] = col_guard_top;
    end
  endgenerate

endmodule

// File: tb/tb_sbox_layer_pipe.sv
module tb_sbox_layer_pipe;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         guards_valid;
  logic         reseed;
  logic [127:0] in_s1, in_s2, in_s3;
  logic [138:0] static_r;
  logic [63:0]  dynamic_r;
  logic [31:0]  guards_in;
  logic         in_ready, out_valid, seeded;
  logic [127:0] out_s1, out_s2, out_s3;
  logic         in_ready2, out_valid2, seeded2;
  logic [63:0]  o2_s1, o2_s2, o2_s3;

  int n_checks = 0;
  int n_fail   = 0;

  sbox_layer_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
    .static_r(static_r), .dynamic_r(dynamic_r),
    .guards_in(guards_in), .guards_valid(guards_valid), .reseed(reseed),
    .out_valid(out_valid), .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
    .seeded(seeded)
  );

  sbox_layer_pipe #(.NUM_COL(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_s1(in_s1[63:0]), .in_s2(in_s2[63:0]), .in_s3(in_s3[63:0]),
    .static_r(static_r), .dynamic_r(dynamic_r),
    .guards_in(guards_in[15:0]), .guards_valid(guards_valid), .reseed(reseed),
    .out_valid(out_valid2), .out_s1(o2_s1), .out_s2(o2_s2), .out_s3(o2_s3),
    .seeded(seeded2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [127:0] subbytes(input logic [127:0] x);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b+:8] = SBOX_T[2047 - 8*int'(x[8*b+:8]) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [138:0] rnd_sr();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[138:0];
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one masked beat of plaintext pt with fresh masks and randomness.
  task automatic drive_beat(input logic [127:0] pt);
    logic [127:0] m2, m3;
    m2 = rnd128();
    m3 = rnd128();
    in_s1     = pt ^ m2 ^ m3;
    in_s2     = m2;
    in_s3     = m3;
    static_r  = rnd_sr();
    dynamic_r = {$urandom, $urandom};
    in_valid  = 1'b1;
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] pt;
    logic [127:0] expq[$];
    logic [127:0] e;
    logic [138:0] exp_rot;
    int vc, n_out, first_cyc, last_cyc;
    logic seen;

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    vecs[2] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[3] = '{128'h53535353535353535353535353535353, 128'hedededededededededededededededed};

    rst = 1'b1; in_valid = 1'b0; guards_valid = 1'b0; reseed = 1'b0;
    in_s1 = '0; in_s2 = '0; in_s3 = '0; static_r = '0; dynamic_r = '0; guards_in = '0;
    #2;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_seeded", seeded, 1'b0);
    check_vec("rst_out_s1", 160'(out_s1), '0);
    check_vec("rst_out_s3", 160'(out_s3), '0);
    step(); step();
    rst = 1'b0;

    // Seeding with guards_valid held high: RUN after the 10th valid cycle.
    guards_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      guards_in = $urandom;
      step();
    end
    check_bit("fill9_seeded", seeded, 1'b0);
    guards_in = $urandom;
    step();
    check_bit("fill10_seeded", seeded, 1'b1);
    check_bit("fill10_ready", in_ready, 1'b1);
    check_bit("fill10_seeded_nc2", seeded2, 1'b1);
    $display("seed: seeded=%b in_ready=%b after 10 guard cycles", seeded, in_ready);

    // Reseed, then seed with guards_valid toggling: only valid cycles count.
    guards_valid = 1'b0;
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    check_bit("reseed_seeded", seeded, 1'b0);
    vc = 0;
    for (int k = 0; k < 20; k++) begin
      guards_valid = k[0];
      guards_in = $urandom;
      step();
      if (k[0]) vc++;
      check_bit("toggle_seeded", seeded, vc >= 10);
    end
    guards_valid = 1'b0;

    // Directed vectors: single beat, latency and unmasked result.
    for (int v = 0; v < 4; v++) begin
      drive_beat(vecs[v].pt);
      step();
      in_valid = 1'b0;
      in_s1 = rnd128(); in_s2 = rnd128(); in_s3 = rnd128();
      step(); step();
      check_bit("lat_early", out_valid, 1'b0);
      step();
      check_bit("lat_valid", out_valid, 1'b1);
      check_vec("vec_result", 160'(out_s1 ^ out_s2 ^ out_s3), 160'(vecs[v].exp));
      check_bit("lat_valid_nc2", out_valid2, 1'b1);
      check_vec("vec_result_nc2", 160'(o2_s1 ^ o2_s2 ^ o2_s3), 160'(vecs[v].exp[63:0]));
      $display("vec %0d pt=%h out=%h", v, vecs[v].pt, out_s1 ^ out_s2 ^ out_s3);
      step();
      check_bit("lat_single", out_valid, 1'b0);
    end

    // Back-to-back burst of 20 beats.
    n_out = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20 + LAT + 3; cyc++) begin
      if (cyc < 20) begin
        pt = rnd128();
        drive_beat(pt);
        expq.push_back(subbytes(pt));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
        if (expq.size() == 0) begin
          check_bit("burst_extra_beat", out_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          check_vec("burst_result", 160'(out_s1 ^ out_s2 ^ out_s3), 160'(e));
          check_vec("burst_result_nc2", 160'(o2_s1 ^ o2_s2 ^ o2_s3), 160'(e[63:0]));
          $display("burst beat %0d out=%h", n_out - 1, out_s1 ^ out_s2 ^ out_s3);
        end
      end
    end
    check_vec("burst_count", 160'(n_out), 160'(20));
    check_vec("burst_consecutive", 160'(last_cyc - first_cyc), 160'(19));

    // reseed together with an accepted beat.
    pt = rnd128();
    drive_beat(pt);
    reseed = 1'b1;
    step();
    in_valid = 1'b0;
    reseed = 1'b0;
    check_bit("reseed_beat_ready", in_ready, 1'b0);
    check_bit("reseed_beat_seeded", seeded, 1'b0);
    step(); step(); step();
    check_bit("reseed_beat_valid", out_valid, 1'b1);
    check_vec("reseed_beat_result", 160'(out_s1 ^ out_s2 ^ out_s3), 160'(subbytes(pt)));
    $display("reseed beat out=%h", out_s1 ^ out_s2 ^ out_s3);
    guards_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      guards_in = $urandom;
      step();
    end
    check_bit("refill9_seeded", seeded, 1'b0);
    step();
    check_bit("refill10_seeded", seeded, 1'b1);
    guards_valid = 1'b0;

    // Reset two cycles after accepting a beat.
    drive_beat(rnd128());
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_seeded", seeded, 1'b0);
    check_bit("midrst_fsm_fill", dut.state_reg == sbox_layer_pkg::FILL, 1'b1);
    for (int k = 0; k < 10; k++) check_vec("midrst_guard_sr", 160'(dut.guard_sr_reg[k]), '0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check_bit("midrst_no_valid", seen, 1'b0);
    check_bit("midrst_still_fill", in_ready, 1'b0);
    $display("mid-reset: in-flight beat discarded");

    // Static randomness probe on byte 0 and byte 1.
    static_r = rnd_sr();
    #1;
`ifdef STATIC_ROTATE_EN
    exp_rot = {static_r[131:0], static_r[138:132]};
`else
    exp_rot = static_r;
`endif
    check_vec("probe_byte0", 160'(dut.g_col[0].u_col.row_sr[0]), 160'(static_r));
    check_vec("probe_byte1", 160'(dut.g_col[0].u_col.row_sr[1]), 160'(exp_rot));
    check_vec("probe_byte1_nc2", 160'(dut2.g_col[0].u_col.row_sr[1]), 160'(exp_rot));
    $display("probe: byte1 static=%h", dut.g_col[0].u_col.row_sr[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
